// File: rtl/pixel_frame_feeder.sv
// Raster frame feeder: forwards size_x*size_y pixels from a valid/ready source to a valid/ready sink with sof/eol/eof markers.
// Optional line blanking is compiled in with `define PIXEL_FEEDER_BLANKING_EN.
module pixel_frame_feeder #(
    parameter int unsigned PIXEL_W     = 8,
    parameter int unsigned DIM_W       = 12,
    parameter int unsigned FRAME_CNT_W = 16,
    parameter int unsigned H_BLANK     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cont,
    input  logic                   abort,
    input  logic [DIM_W-1:0]       size_x,
    input  logic [DIM_W-1:0]       size_y,
    input  logic [PIXEL_W-1:0]     src_pixel,
    input  logic                   src_valid,
    output logic                   src_ready,
    output logic [PIXEL_W-1:0]     pixel_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sof,
    output logic                   eol,
    output logic                   eof,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_DRAIN,
        ST_READY
`ifdef PIXEL_FEEDER_BLANKING_EN
        ,
        ST_BLANK
`endif
    } state_t;

`ifdef PIXEL_FEEDER_BLANKING_EN
    localparam int unsigned BLANK_W = 8;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
`else
    logic unused_h_blank;
    assign unused_h_blank = ^H_BLANK;
`endif

    state_t                 state_q, state_d;
    logic [DIM_W-1:0]       size_x_q, size_x_d;
    logic [DIM_W-1:0]       size_y_q, size_y_d;
    logic [DIM_W-1:0]       x_q, x_d;
    logic [DIM_W-1:0]       y_q, y_d;
    logic [PIXEL_W-1:0]     pixel_out_q, pixel_out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   sof_q, sof_d;
    logic                   eol_q, eol_d;
    logic                   eof_q, eof_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic                   src_ready_c;
    logic                   last_x_c;
    logic                   last_y_c;
    logic                   xfer_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            size_x_q      <= '0;
            size_y_q      <= '0;
            x_q           <= '0;
            y_q           <= '0;
            pixel_out_q   <= '0;
            out_valid_q   <= 1'b0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            eof_q         <= 1'b0;
            frame_count_q <= '0;
`ifdef PIXEL_FEEDER_BLANKING_EN
            blank_cnt_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            size_x_q      <= size_x_d;
            size_y_q      <= size_y_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pixel_out_q   <= pixel_out_d;
            out_valid_q   <= out_valid_d;
            sof_q         <= sof_d;
            eol_q         <= eol_d;
            eof_q         <= eof_d;
            frame_count_q <= frame_count_d;
`ifdef PIXEL_FEEDER_BLANKING_EN
            blank_cnt_q   <= blank_cnt_d;
`endif
        end
    end

    // Next-state, counters and one-entry output register
    always_comb begin
        state_d       = state_q;
        size_x_d      = size_x_q;
        size_y_d      = size_y_q;
        x_d           = x_q;
        y_d           = y_q;
        pixel_out_d   = pixel_out_q;
        out_valid_d   = out_valid_q;
        sof_d         = sof_q;
        eol_d         = eol_q;
        eof_d         = eof_q;
        frame_count_d = frame_count_q;
`ifdef PIXEL_FEEDER_BLANKING_EN
        blank_cnt_d   = blank_cnt_q;
`endif
        src_ready_c   = 1'b0;
        last_x_c      = (x_q == (size_x_q - DIM_W'(1)));
        last_y_c      = (y_q == (size_y_q - DIM_W'(1)));
        xfer_c        = out_valid_q && out_ready;

        if (xfer_c) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    size_x_d = size_x;
                    size_y_d = size_y;
                    x_d      = '0;
                    y_d      = '0;
                    state_d  = ((size_x == '0) || (size_y == '0)) ? ST_READY : ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                src_ready_c = !out_valid_q || out_ready;
                if (src_valid && src_ready_c) begin
                    pixel_out_d = src_pixel;
                    out_valid_d = 1'b1;
                    sof_d       = (x_q == '0) && (y_q == '0);
                    eol_d       = last_x_c;
                    eof_d       = last_x_c && last_y_c;
                    if (last_x_c) begin
                        x_d = '0;
                        y_d = y_q + DIM_W'(1);
                        if (last_y_c) begin
                            state_d = ST_DRAIN;
                        end else begin
`ifdef PIXEL_FEEDER_BLANKING_EN
                            state_d     = ST_BLANK;
                            blank_cnt_d = '0;
`endif
                        end
                    end else begin
                        x_d = x_q + DIM_W'(1);
                    end
                end
            end
`ifdef PIXEL_FEEDER_BLANKING_EN
            ST_BLANK: begin
                if (blank_cnt_q == BLANK_W'(H_BLANK - 1)) begin
                    blank_cnt_d = '0;
                    state_d     = ST_RUNNING;
                end else begin
                    blank_cnt_d = blank_cnt_q + BLANK_W'(1);
                end
            end
`endif
            ST_DRAIN: begin
                if (xfer_c) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                frame_count_d = frame_count_q + FRAME_CNT_W'(1);
                x_d           = '0;
                y_d           = '0;
                // An empty latched frame in continuous mode repeats as empty frames
                if (cont) begin
                    state_d = ((size_x_q == '0) || (size_y_q == '0)) ? ST_READY : ST_RUNNING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d       = ST_IDLE;
            out_valid_d   = 1'b0;
            x_d           = '0;
            y_d           = '0;
            frame_count_d = frame_count_q;
`ifdef PIXEL_FEEDER_BLANKING_EN
            blank_cnt_d   = '0;
`endif
        end
    end

    assign src_ready   = src_ready_c;
    assign pixel_out   = pixel_out_q;
    assign out_valid   = out_valid_q;
    assign sof         = sof_q;
    assign eol         = eol_q;
    assign eof         = eof_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_READY);
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_frame_feeder.sv
// Randomized bench for pixel_frame_feeder; expected streams come from frame geometry (index -> markers) and a pixel queue.
module tb_pixel_frame_feeder;

    localparam int unsigned PW = 8;
    localparam int unsigned DW = 12;
    localparam int unsigned FW = 16;
    localparam int unsigned HB = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          cont;
    logic          abort;
    logic [DW-1:0] size_x;
    logic [DW-1:0] size_y;
    logic [PW-1:0] src_pixel;
    logic          src_valid;
    logic          src_ready;
    logic [PW-1:0] pixel_out;
    logic          out_valid;
    logic          out_ready;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          busy;
    logic          done;
    logic [FW-1:0] frame_count;

    int checks = 0;
    int errors = 0;
    int exp_fc = 0;

    pixel_frame_feeder #(
        .PIXEL_W(PW), .DIM_W(DW), .FRAME_CNT_W(FW), .H_BLANK(HB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
        .size_x(size_x), .size_y(size_y),
        .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(src_ready),
        .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready),
        .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Feed one frame (start must already be raised) and score every output beat by its raster index.
    // vmode: 0 always valid, 1 random; rmode: 0 always ready, 1 pattern 1,0,0, 2 random.
    task automatic run_frame(input int sx, input int sy, input int vmode, input int rmode,
                             input bit cont_mode, output int cyc);
        logic [PW-1:0]   pix_q[$];
        logic [PW+2:0]   held;
        bit              stalled;
        int              in_idx;
        int              out_idx;
        int              total;
        total   = sx * sy;
        in_idx  = 0;
        out_idx = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        for (int i = 0; i < total; i++) pix_q.push_back(PW'($urandom));
        while (out_idx < total && cyc < 30 * total + 200) begin
            @(negedge clk);
            start     = 1'b0;
            src_valid = (in_idx < total) && (vmode == 0 || $urandom_range(0, 3) != 0);
            src_pixel = (in_idx < total) ? pix_q[in_idx] : PW'(0);
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (stalled) begin
                checks++;
                if ({pixel_out, sof, eol, eof} !== held) begin
                    errors++;
                    $display("FAIL hold: got %h want %h (beat %0d)", {pixel_out, sof, eol, eof}, held, out_idx);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (src_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL src_ready_stall: got %b want 0", src_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({pixel_out, sof, eol, eof} !==
                    {pix_q[out_idx], 1'(out_idx == 0), 1'(out_idx % sx == sx - 1), 1'(out_idx == total - 1)}) begin
                    errors++;
                    $display("FAIL beat %0d of %0dx%0d: got pix=%h sof=%b eol=%b eof=%b want pix=%h sof=%b eol=%b eof=%b",
                             out_idx, sx, sy, pixel_out, sof, eol, eof, pix_q[out_idx],
                             out_idx == 0, out_idx % sx == sx - 1, out_idx == total - 1);
                end
                out_idx++;
            end
            if (src_valid && src_ready) in_idx++;
            stalled = out_valid && !out_ready;
            held    = {pixel_out, sof, eol, eof};
            cyc++;
        end
        checks++;
        if (out_idx != total) begin
            errors++;
            $display("FAIL frame_timeout: got %0d beats want %0d", out_idx, total);
        end
        @(negedge clk);
        src_valid = 1'b0;
        #1;
        exp_fc++;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_after_eof: got %b want 1", done);
        end
        if (!cont_mode) begin
            @(negedge clk);
            #1;
            checks++;
            if ({done, busy, frame_count} !== {1'b0, 1'b0, FW'(exp_fc)}) begin
                errors++;
                $display("FAIL frame_end: got done=%b busy=%b fc=%0d want 0 0 %0d", done, busy, frame_count, exp_fc);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        exp_fc = 0;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({src_ready, out_valid, sof, eol, eof, busy, done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000", {src_ready, out_valid, sof, eol, eof, busy, done});
        end
        checks++;
        if ({pixel_out, frame_count} !== '0) begin
            errors++;
            $display("FAIL reset_data: got pix=%h fc=%0d want 0 0", pixel_out, frame_count);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        int exp_cyc;
        @(negedge clk);
        size_x = DW'(4);
        size_y = DW'(3);
        start  = 1'b1;
        run_frame(4, 3, 0, 0, 1'b0, cyc);
`ifdef PIXEL_FEEDER_BLANKING_EN
        exp_cyc = 13 + 2 * HB;
`else
        exp_cyc = 13;
`endif
        checks++;
        if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL basic_throughput: got %0d cycles want %0d", cyc, exp_cyc);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        @(negedge clk);
        size_x = DW'(4);
        size_y = DW'(2);
        start  = 1'b1;
        run_frame(4, 2, 0, 1, 1'b0, cyc);
    endtask

    task automatic test_random();
        int cyc;
        int sx;
        int sy;
        for (int f = 0; f < 8; f++) begin
            sx = (f == 0) ? 1 : (f == 1) ? 1 : (f == 2) ? 5 : $urandom_range(1, 6);
            sy = (f == 0) ? 1 : (f == 1) ? 4 : (f == 2) ? 1 : $urandom_range(1, 5);
            @(negedge clk);
            size_x = DW'(sx);
            size_y = DW'(sy);
            start  = 1'b1;
            run_frame(sx, sy, 1, 2, 1'b0, cyc);
        end
    endtask

    task automatic test_zero_size();
        @(negedge clk);
        size_x = DW'(0);
        size_y = DW'(5);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if ({done, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL zero_done: got done=%b out_valid=%b want 1 0", done, out_valid);
        end
        @(negedge clk);
        #1;
        exp_fc++;
        checks++;
        if ({done, busy, out_valid, frame_count} !== {3'b000, FW'(exp_fc)}) begin
            errors++;
            $display("FAIL zero_end: got done=%b busy=%b ov=%b fc=%0d want 0 0 0 %0d",
                     done, busy, out_valid, frame_count, exp_fc);
        end
    endtask

    task automatic test_cont_abort();
        int cyc;
        do_reset();
        cont = 1'b1;
        @(negedge clk);
        size_x = DW'(2);
        size_y = DW'(2);
        start  = 1'b1;
        run_frame(2, 2, 0, 0, 1'b1, cyc);
        size_x = DW'(9);
        size_y = DW'(9);
        run_frame(2, 2, 1, 2, 1'b1, cyc);
        run_frame(2, 2, 1, 2, 1'b1, cyc);
        @(negedge clk);
        src_valid = 1'b1;
        src_pixel = PW'($urandom);
        out_ready = 1'b0;
        @(negedge clk);
        src_valid = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid} !== 2'b11) begin
            errors++;
            $display("FAIL cont_fourth_frame: got busy=%b ov=%b want 1 1", busy, out_valid);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cont  = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, done, src_ready, frame_count} !== {4'b0000, FW'(3)}) begin
            errors++;
            $display("FAIL abort: got busy=%b ov=%b done=%b sr=%b fc=%0d want 0 0 0 0 3",
                     busy, out_valid, done, src_ready, frame_count);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, frame_count} !== {1'b0, FW'(3)}) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b fc=%0d want 0 3", busy, frame_count);
        end
        exp_fc = 3;
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(negedge clk);
        size_x = DW'(8);
        size_y = DW'(8);
        start  = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        src_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            src_pixel = PW'(i + 1);
            @(negedge clk);
        end
        src_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({src_ready, out_valid, sof, eol, eof, busy, done, pixel_out, frame_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got sr=%b ov=%b busy=%b done=%b pix=%h fc=%0d want all 0",
                     src_ready, out_valid, busy, done, pixel_out, frame_count);
        end
        @(negedge clk);
        rst    = 1'b1;
        exp_fc = 0;
        @(negedge clk);
        start = 1'b1;
        run_frame(8, 8, 1, 2, 1'b0, cyc);
    endtask

`ifdef PIXEL_FEEDER_BLANKING_EN
    task automatic test_blanking();
        int acc[$];
        int seen_done;
        @(negedge clk);
        size_x    = DW'(3);
        size_y    = DW'(2);
        start     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && acc.size() < 6; c++) begin
            @(negedge clk);
            start     = 1'b0;
            src_valid = 1'b1;
            src_pixel = PW'($urandom);
            #1;
            if (src_ready) acc.push_back(c);
        end
        src_valid = 1'b0;
        checks++;
        if (acc.size() != 6) begin
            errors++;
            $display("FAIL blank_accepts: got %0d want 6", acc.size());
        end else begin
            checks++;
            if ({acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2], acc[4] - acc[3], acc[5] - acc[4]} !==
                {32'd1, 32'd1, 32'(HB + 1), 32'd1, 32'd1}) begin
                errors++;
                $display("FAIL blank_gap: got gap %0d want %0d", acc[3] - acc[2], HB + 1);
            end
        end
        seen_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (done) seen_done++;
        end
        exp_fc++;
        checks++;
        if (seen_done != 1 || frame_count !== FW'(exp_fc)) begin
            errors++;
            $display("FAIL blank_done: got pulses=%0d fc=%0d want 1 %0d", seen_done, frame_count, exp_fc);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cont      = 1'b0;
        abort     = 1'b0;
        size_x    = '0;
        size_y    = '0;
        src_pixel = '0;
        src_valid = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_zero_size();
        test_cont_abort();
        test_reset_mid();
`ifdef PIXEL_FEEDER_BLANKING_EN
        test_blanking();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
